// File: rtl/mem_arbiter_2m_if.sv
// One picorv32 native memory link. The requester side uses the master modport,
// the responding side the slave modport.
interface mem_arbiter_2m_if;
  // valid is raised with a stable addr/wdata/wstrb payload and held until ready;
  // ready is a single-cycle completion pulse and rdata is only meaningful with it.
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_arbiter_2m.sv
// Round-robin arbiter sharing one memory slave between two masters, with a bus
// watchdog that completes stalled transfers with an error word.
module mem_arbiter_2m #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              resetn,
  mem_arbiter_2m_if.slave   m0,
  mem_arbiter_2m_if.slave   m1,
  mem_arbiter_2m_if.master  s,
  output logic              err,
  output logic [31:0]       err_addr,
  output logic              err_master,
  input  logic              err_clr,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    TOUT = 2'd3
  } state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        last;
  logic        owner;
  logic [15:0] wd_cnt;
  logic        gnt0;
  logic        gnt1;
  logic        tout;

  // Bus-side outputs decode from state only, so reset drops them immediately.
  always_comb begin
    gnt0      = (state == GNT0);
    gnt1      = (state == GNT1);
    tout      = (state == TOUT);
    dbg_state = state;

    s.valid = gnt0 | gnt1;
    s.addr  = '0;
    s.wdata = '0;
    s.wstrb = '0;
    if (gnt0) begin
      s.addr  = m0.addr;
      s.wdata = m0.wdata;
      s.wstrb = m0.wstrb;
    end else if (gnt1) begin
      s.addr  = m1.addr;
      s.wdata = m1.wdata;
      s.wstrb = m1.wstrb;
    end

    m0.ready = (gnt0 && s.ready) || (tout && !owner);
    m1.ready = (gnt1 && s.ready) || (tout && owner);

    m0.rdata = '0;
    m1.rdata = '0;
    if (gnt0) begin
      m0.rdata = s.rdata;
    end else if (gnt1) begin
      m1.rdata = s.rdata;
    end else if (tout) begin
      if (owner) m1.rdata = TIMEOUT_RDATA;
      else       m0.rdata = TIMEOUT_RDATA;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last       <= 1'b1;
      owner      <= 1'b0;
      wd_cnt     <= '0;
      err        <= 1'b0;
      err_addr   <= '0;
      err_master <= 1'b0;
    end else begin
      if (err_clr) err <= 1'b0;

      case (state)
        IDLE: begin
          wd_cnt <= '0;
          // On a tie, last == 1 means m1 was served last, so m0 goes next.
          if (m0.valid && (!m1.valid || last)) begin
            state <= GNT0;
            owner <= 1'b0;
            last  <= 1'b0;
          end else if (m1.valid) begin
            state <= GNT1;
            owner <= 1'b1;
            last  <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (s.ready) begin
            state <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
            if (wd_cnt == WD_LAST) state <= TOUT;
          end
        end
        TOUT: begin
          state <= IDLE;
          // First-fault capture; a same-cycle clear lets a new fault re-arm it.
          if (!err || err_clr) begin
            err        <= 1'b1;
            err_addr   <= owner ? m1.addr : m0.addr;
            err_master <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
